snake_dir_ctrl: RTL and testbench

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

---
 rtl/snake_dir_ctrl_pkg.sv | 25 ++
 rtl/snake_dir_ctrl_btn_debounce.sv | 70 +++++++
 rtl/snake_dir_ctrl.sv | 159 +++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_dir_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// snake_dir_ctrl_pkg
// Shared definitions for the snake direction controller and its consumers:
//   - direction codes (2 bits) used on the direction output and in the queue
//   - game state codes (3 bits) presented on game_state
//   - reverse_dir(): opposite heading of a direction code
// -----------------------------------------------------------------------------
package snake_dir_ctrl_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [2:0] STATE_START    = 3'd0;
  localparam logic [2:0] STATE_INGAME   = 3'd1;
  localparam logic [2:0] STATE_PAUSE    = 3'd2;
  localparam logic [2:0] STATE_GAMEOVER = 3'd3;

  // Opposite headings differ only in the upper bit of the encoding.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One push-button front end: 2-flop synchroniser, debounce counter and
// rising-edge detector on the debounced level.
// Ports:
//   sys_clk      in   system clock
//   sys_reset_n  in   asynchronous active-low reset
//   btn_raw      in   raw asynchronous button, active-high
//   press        out  one-cycle pulse on each accepted 0->1 debounced edge
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic sys_clk,
  input  logic sys_reset_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter tracks how many consecutive cycles the synchronised input has
  // disagreed with the accepted level; any agreement restarts it from zero.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  // Both history flops clear together in reset, so releasing reset with the
  // button held cannot fabricate an edge.
  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// snake_dir_ctrl
// Turns four push-buttons into a snake heading. Accepted presses are buffered
// in a 2-entry turn queue and applied one per game step (update_tick).
// Ports:
//   sys_clk       in   system clock (single domain)
//   sys_reset_n   in   asynchronous active-low reset
//   btn_up/right/down/left  in  raw push-buttons, active-high
//   update_tick   in   one-cycle game step pulse
//   game_state    in   [2:0] current game state code
//   direction     out  [1:0] current heading
//   turn_pending  out  queue non-empty (registered)
//   queue_full    out  queue holds 2 entries (registered)
// -----------------------------------------------------------------------------
module snake_dir_ctrl
  import snake_dir_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       update_tick,
  input  logic [2:0] game_state,
  output logic [1:0] direction,
  output logic       turn_pending,
  output logic       queue_full
);

  // Indexed by direction code so the winning index is the pushed value.
  logic [3:0] press_vec;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .btn_raw(btn_up),    .press(press_vec[0])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .btn_raw(btn_right), .press(press_vec[1])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .btn_raw(btn_down),  .press(press_vec[2])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_left (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .btn_raw(btn_left),  .press(press_vec[3])
  );

  // Turn queue: head_q is the oldest entry, tail_q the second; count_q is 0..2.
  logic [1:0] dir_q,     dir_d;
  logic [1:0] head_q,    head_d;
  logic [1:0] tail_q,    tail_d;
  logic [1:0] count_q,   count_d;
  logic       pending_q, pending_d;
  logic       full_q,    full_d;

  logic       press_any;
  logic [1:0] press_dir;
  logic [1:0] ref_dir;
  logic       in_game;
  logic       in_start;
  logic       do_pop;
  logic       do_push;

  // Simultaneous presses: up > right > down > left, the rest are discarded.
  always_comb begin
    press_any = |press_vec;
    press_dir = DIR_UP;
    if (press_vec[0]) begin
      press_dir = DIR_UP;
    end else if (press_vec[1]) begin
      press_dir = DIR_RIGHT;
    end else if (press_vec[2]) begin
      press_dir = DIR_DOWN;
    end else if (press_vec[3]) begin
      press_dir = DIR_LEFT;
    end
  end

  assign in_game  = (game_state == STATE_INGAME);
  assign in_start = (game_state == STATE_START);

  // A new turn is judged against the last heading the snake will have taken,
  // i.e. the newest queued entry, before any pop happening this cycle.
  assign ref_dir = (count_q == 2'd0) ? dir_q :
                   (count_q == 2'd1) ? head_q : tail_q;

  assign do_pop  = in_game & update_tick & (count_q != 2'd0);
  assign do_push = in_game & press_any
                 & (press_dir != ref_dir)
                 & (press_dir != reverse_dir(ref_dir))
                 & ((count_q != 2'd2) | do_pop);

  always_comb begin
    dir_d   = dir_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (in_start) begin
      dir_d   = DIR_RIGHT;
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        dir_d = head_q;
      end
      case ({do_pop, do_push})
        2'b11: begin
          // Occupancy unchanged: the survivor shifts to head, push goes behind.
          if (count_q == 2'd1) begin
            head_d = press_dir;
          end else begin
            head_d = tail_q;
            tail_d = press_dir;
          end
        end
        2'b10: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) begin
            head_d = press_dir;
          end else begin
            tail_d = press_dir;
          end
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end

    pending_d = (count_d != 2'd0);
    full_d    = (count_d == 2'd2);
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      dir_q     <= DIR_RIGHT;
      head_q    <= DIR_UP;
      tail_q    <= DIR_UP;
      count_q   <= 2'd0;
      pending_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      full_q    <= full_d;
    end
  end

  assign direction    = dir_q;
  assign turn_pending = pending_q;
  assign queue_full   = full_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;
  import snake_dir_ctrl_pkg::*;

  localparam int DB = 4;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n;
  logic       btn_up, btn_right, btn_down, btn_left;
  logic       update_tick;
  logic [2:0] game_state;
  logic [1:0] direction;
  logic       turn_pending;
  logic       queue_full;

  int checks = 0;
  int errors = 0;

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(DB)) u_dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .btn_up      (btn_up),
    .btn_right   (btn_right),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .update_tick (update_tick),
    .game_state  (game_state),
    .direction   (direction),
    .turn_pending(turn_pending),
    .queue_full  (queue_full)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------------------
  // Reference model: raw inputs are delayed two samples, a button level is
  // accepted after DB consecutive disagreeing samples, a rise of the accepted
  // level is a press usable one step later. Turns live in a plain queue.
  // ---------------------------------------------------------------------------
  logic [3:0] m_sync1, m_sync2, m_lvl, m_rose;
  int         m_run[4];
  logic [1:0] m_q[$];
  logic [1:0] m_dir;

  task automatic model_reset();
    m_sync1 = '0; m_sync2 = '0; m_lvl = '0; m_rose = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_q.delete();
    m_dir = DIR_RIGHT;
  endtask

  task automatic model_step();
    logic [3:0] raw, ev;
    logic [1:0] sel, refd;
    bit         have, pop, acc;
    raw  = {btn_left, btn_down, btn_right, btn_up};
    ev   = m_rose;
    sel  = DIR_UP;
    have = 1'b0;
    if (game_state == STATE_START) begin
      m_dir = DIR_RIGHT;
      m_q.delete();
    end else if (game_state == STATE_INGAME) begin
      for (int i = 0; i < 4; i++) begin
        if (ev[i] && !have) begin
          have = 1'b1;
          sel  = 2'(i);
        end
      end
      refd = (m_q.size() > 0) ? m_q[$] : m_dir;
      pop  = update_tick && (m_q.size() > 0);
      acc  = have && (sel != refd) && (sel != (refd ^ 2'b10)) && ((m_q.size() < 2) || pop);
      if (pop) m_dir = m_q.pop_front();
      if (acc) m_q.push_back(sel);
    end
    for (int i = 0; i < 4; i++) begin
      m_rose[i] = 1'b0;
      if (m_sync2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i]  = m_sync2[i];
          m_run[i]  = 0;
          m_rose[i] = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_sync2 = m_sync1;
    m_sync1 = raw;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_reset_n = 1'b0;
    btn_up = 0; btn_right = 0; btn_down = 0; btn_left = 0;
    update_tick = 0;
    game_state  = STATE_INGAME;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    sys_reset_n = 1'b0;
    btn_up = 1; btn_right = 1; btn_down = 0; btn_left = 0;
    update_tick = 1;
    game_state  = STATE_INGAME;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (direction !== DIR_RIGHT) begin errors++; $display("FAIL reset_direction got %b want %b", direction, DIR_RIGHT); end
    checks++;
    if (turn_pending !== 1'b0) begin errors++; $display("FAIL reset_turn_pending got %b want 0", turn_pending); end
    checks++;
    if (queue_full !== 1'b0) begin errors++; $display("FAIL reset_queue_full got %b want 0", queue_full); end
  endtask

  task automatic test_basic_turn();
    do_reset();
    btn_up = 1;
    repeat (6) cyc();
    checks++;
    if (turn_pending !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", turn_pending); end
    cyc();
    checks++;
    if (turn_pending !== 1'b1) begin errors++; $display("FAIL latency_push got %b want 1", turn_pending); end
    checks++;
    if (direction !== DIR_RIGHT) begin errors++; $display("FAIL dir_before_tick got %b want %b", direction, DIR_RIGHT); end
    repeat (3) cyc();
    btn_up = 0;
    update_tick = 1;
    cyc();
    update_tick = 0;
    checks++;
    if (direction !== DIR_UP) begin errors++; $display("FAIL dir_after_tick got %b want %b", direction, DIR_UP); end
    checks++;
    if (turn_pending !== 1'b0) begin errors++; $display("FAIL pending_after_tick got %b want 0", turn_pending); end
  endtask

  task automatic test_reject();
    bit seen;
    do_reset();
    seen = 0;
    btn_left = 1;
    repeat (10) begin cyc(); if (turn_pending) seen = 1; end
    btn_left = 0;
    repeat (8) begin cyc(); if (turn_pending) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reverse_dropped got pending=%b want 0", seen); end
    seen = 0;
    btn_right = 1;
    repeat (10) begin cyc(); if (turn_pending) seen = 1; end
    btn_right = 0;
    repeat (8) begin cyc(); if (turn_pending) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL same_dropped got pending=%b want 0", seen); end
    checks++;
    if (direction !== DIR_RIGHT) begin errors++; $display("FAIL reject_direction got %b want %b", direction, DIR_RIGHT); end
  endtask

  task automatic test_queue_full();
    do_reset();
    btn_up = 1;   repeat (8) cyc(); btn_up = 0;
    btn_left = 1; repeat (8) cyc(); btn_left = 0;
    btn_down = 1; repeat (8) cyc(); btn_down = 0;
    repeat (8) cyc();
    checks++;
    if (queue_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", queue_full); end
    checks++;
    if (direction !== DIR_RIGHT) begin errors++; $display("FAIL full_dir_hold got %b want %b", direction, DIR_RIGHT); end
    update_tick = 1; cyc(); update_tick = 0;
    checks++;
    if (direction !== DIR_UP || queue_full !== 1'b0 || turn_pending !== 1'b1) begin
      errors++;
      $display("FAIL full_pop1 got dir=%b full=%b pend=%b want dir=00 full=0 pend=1", direction, queue_full, turn_pending);
    end
    update_tick = 1; cyc(); update_tick = 0;
    checks++;
    if (direction !== DIR_LEFT || turn_pending !== 1'b0) begin
      errors++;
      $display("FAIL full_pop2 got dir=%b pend=%b want dir=11 pend=0", direction, turn_pending);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_down = ~btn_down;
      cyc();
      if (turn_pending) seen = 1;
    end
    btn_down = 0;
    repeat (10) begin cyc(); if (turn_pending) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL bounce_no_push got pending=%b want 0", seen); end
    checks++;
    if (direction !== DIR_RIGHT) begin errors++; $display("FAIL bounce_direction got %b want %b", direction, DIR_RIGHT); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    btn_up = 1; repeat (7) cyc(); btn_up = 0;
    checks++;
    if (turn_pending !== 1'b1 || queue_full !== 1'b0) begin
      errors++;
      $display("FAIL b2b_setup got pend=%b full=%b want pend=1 full=0", turn_pending, queue_full);
    end
    btn_left = 1;
    repeat (6) cyc();
    update_tick = 1; cyc(); update_tick = 0;
    btn_left = 0;
    checks++;
    if (direction !== DIR_UP || turn_pending !== 1'b1 || queue_full !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pushpop got dir=%b pend=%b full=%b want dir=00 pend=1 full=0", direction, turn_pending, queue_full);
    end
    update_tick = 1; cyc(); update_tick = 0;
    checks++;
    if (direction !== DIR_LEFT || turn_pending !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got dir=%b pend=%b want dir=11 pend=0", direction, turn_pending);
    end
  endtask

  task automatic test_start_clear();
    do_reset();
    btn_up = 1; repeat (8) cyc(); btn_up = 0;
    update_tick = 1; cyc(); update_tick = 0;
    btn_left = 1; repeat (8) cyc(); btn_left = 0;
    game_state = STATE_START;
    update_tick = 1;
    cyc();
    update_tick = 0;
    checks++;
    if (direction !== DIR_RIGHT || turn_pending !== 1'b0 || queue_full !== 1'b0) begin
      errors++;
      $display("FAIL start_clear got dir=%b pend=%b full=%b want dir=01 pend=0 full=0", direction, turn_pending, queue_full);
    end
    game_state = STATE_INGAME;
    btn_up = 1; repeat (8) cyc(); btn_up = 0;
    btn_left = 1;
    repeat (3) cyc();
    #2;
    sys_reset_n = 1'b0;
    #1;
    checks++;
    if (direction !== DIR_RIGHT || turn_pending !== 1'b0 || queue_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got dir=%b pend=%b full=%b want dir=01 pend=0 full=0", direction, turn_pending, queue_full);
    end
    btn_left = 0;
    @(posedge sys_clk);
    #1;
    sys_reset_n = 1'b1;
    model_reset();
    repeat (12) cyc();
    checks++;
    if (turn_pending !== 1'b0 || direction !== DIR_RIGHT) begin
      errors++;
      $display("FAIL reset_release_no_press got dir=%b pend=%b want dir=01 pend=0", direction, turn_pending);
    end
  endtask

  task automatic test_random();
    int hold[4];
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          hold[i] = $urandom_range(1, 12);
          case (i)
            0: btn_up    = $urandom_range(0, 1);
            1: btn_right = $urandom_range(0, 1);
            2: btn_down  = $urandom_range(0, 1);
            default: btn_left = $urandom_range(0, 1);
          endcase
        end else begin
          hold[i]--;
        end
      end
      update_tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 5))
          0: game_state = STATE_START;
          1: game_state = STATE_PAUSE;
          2: game_state = STATE_GAMEOVER;
          default: game_state = STATE_INGAME;
        endcase
      end
      cyc();
      checks++;
      if (direction !== m_dir || turn_pending !== (m_q.size() > 0) || queue_full !== (m_q.size() == 2)) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle_%0d got dir=%b pend=%b full=%b want dir=%b pend=%0d full=%0d",
                   n, direction, turn_pending, queue_full, m_dir, (m_q.size() > 0), (m_q.size() == 2));
      end
    end
    update_tick = 0;
  endtask

  initial begin
    sys_reset_n = 1'b0;
    btn_up = 0; btn_right = 0; btn_down = 0; btn_left = 0;
    update_tick = 0;
    game_state  = STATE_START;
    model_reset();
    test_reset();
    test_basic_turn();
    test_reject();
    test_queue_full();
    test_bounce();
    test_back_to_back();
    test_start_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
